// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: byte width, the default
// FIFO depth and the launch-sequencer state encoding.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int TXF_DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } txf_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
// Byte storage for the transmit FIFO: DEPTH entries of UART_DATA_W bits,
// synchronous write and combinational (asynchronous) read.
// Ports:
//   clock      - write clock
//   writeEn    - store writeData at writeAddr on the rising edge
//   writeAddr  - write pointer
//   writeData  - byte to store
//   readAddr   - read pointer
//   readData   - byte currently at readAddr
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = TXF_DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic                   clock,
  input  logic                   writeEn,
  input  logic [ADDR_W-1:0]      writeAddr,
  input  logic [UART_DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0]      readAddr,
  output logic [UART_DATA_W-1:0] readData
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  assign readData = mem[readAddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Circular byte FIFO plus launch sequencer in front of a UART transmitter.
// Bytes are accepted at up to one per clock and handed to the transmitter one
// frame at a time: a one-cycle tx_start pulse with tx_data, then a wait for the
// rising edge of tx_done before the next byte is launched.
// Ports:
//   clock     - single clock, rising edge
//   reset     - asynchronous, active-low reset
//   wr_data   - byte to enqueue
//   wr_en     - enqueue strobe
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - stored bytes, not including the byte in flight
//   overflow  - sticky, set by a write attempted while full
//   tx_data   - byte presented to the transmitter
//   tx_start  - one-cycle launch pulse
//   tx_done   - transmitter frame-complete, rising edge used
//   busy      - a frame has been launched and is not yet complete
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = TXF_DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   busy
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

  txf_state_t state;
  txf_state_t nextState;

  logic [ADDR_W-1:0]      wrPtr;
  logic [ADDR_W-1:0]      rdPtr;
  logic [ADDR_W:0]        countNext;
  logic [UART_DATA_W-1:0] readData;
  logic                   txDoneQ;
  logic                   doWrite;
  logic                   doPop;
  logic                   doneRise;

  // full is the registered flag, so a write in the same cycle as a pop out of
  // a full FIFO is still refused.
  assign doWrite  = wr_en && !full;
  assign doneRise = tx_done && !txDoneQ;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) fifoMem (
    .clock     (clock),
    .writeEn   (doWrite),
    .writeAddr (wrPtr),
    .writeData (wr_data),
    .readAddr  (rdPtr),
    .readData  (readData)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. The byte is popped on the edge that enters LAUNCH, so
  // tx_data is already valid during the cycle tx_start is high. Edges of
  // tx_done seen outside WAIT are ignored.
  always_comb begin
    nextState = state;
    doPop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          nextState = LAUNCH;
          doPop     = 1'b1;
        end
      end
      LAUNCH: nextState = WAIT;
      WAIT: begin
        if (doneRise) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Occupancy after this edge; a simultaneous write and pop cancel out.
  always_comb begin
    countNext = count;
    unique case ({doWrite, doPop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Pointers, count, flags and transmitter outputs, all registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      txDoneQ  <= 1'b0;
    end else begin
      txDoneQ  <= tx_done;
      count    <= countNext;
      full     <= (countNext == FullCount);
      empty    <= (countNext == '0);
      tx_start <= doPop;
      busy     <= (nextState != IDLE);
      if (doWrite) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr   <= rdPtr + 1'b1;
        tx_data <= readData;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A queue-based model predicts every
// registered output each clock; a transmitter model drives tx_done and feeds a
// scoreboard of accepted bytes. Directed literal checks pin the model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TX_AUTO = 0;
  localparam int TX_LOW  = 1;
  localparam int TX_HIGH = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              wr_en = 1'b0;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done = 1'b0;
  logic              busy;

  always #5 clock = ~clock;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a queue of stored bytes plus frame-level bookkeeping.
  byte unsigned mQ[$];
  byte unsigned expQ[$];
  byte unsigned rxLog[$];
  logic       mBusy = 1'b0;
  logic       mStart = 1'b0;
  logic       mOverflow = 1'b0;
  logic       mDoneQ = 1'b0;
  logic [7:0] mTxData = 8'h00;
  int         peakCount = 0;

  task automatic modelReset();
    mQ.delete();
    expQ.delete();
    mBusy     = 1'b0;
    mStart    = 1'b0;
    mOverflow = 1'b0;
    mDoneQ    = 1'b0;
    mTxData   = 8'h00;
  endtask

  always @(negedge reset) modelReset();

  // Advance the model on each edge, then compare all outputs just after it.
  always @(posedge clock) begin : compareProc
    logic rise;
    logic launchNow;
    logic finishNow;
    logic accept;
    int   sizeBefore;
    if (!reset) begin
      modelReset();
    end else begin
      sizeBefore = mQ.size();
      rise       = tx_done && !mDoneQ;
      mDoneQ     = tx_done;
      launchNow  = !mBusy && (sizeBefore > 0);
      finishNow  = mBusy && !mStart && rise;
      accept     = wr_en && (sizeBefore < DEPTH);
      if (wr_en && !accept) mOverflow = 1'b1;
      if (launchNow) mTxData = mQ.pop_front();
      if (accept) begin
        mQ.push_back(wr_data);
        expQ.push_back(wr_data);
      end
      mBusy  = launchNow || (mBusy && !finishNow);
      mStart = launchNow;
    end
    #1;
    checkOutput("count", count, mQ.size());
    checkOutput("full", full, mQ.size() == DEPTH);
    checkOutput("empty", empty, mQ.size() == 0);
    checkOutput("overflow", overflow, mOverflow);
    checkOutput("txData", tx_data, mTxData);
    checkOutput("txStart", tx_start, mStart);
    checkOutput("busy", busy, mBusy);
    if (int'(count) > peakCount) peakCount = int'(count);
  end

  // Transmitter model: logs launched bytes, then raises tx_done for two cycles
  // once its latency has elapsed (AUTO), or holds tx_done low/high.
  int txMode = TX_LOW;
  int txLatency = 3;
  bit randLatency = 1'b0;
  bit txPending = 1'b0;
  int txCd = 0;
  int txHold = 0;

  always @(negedge clock) begin
    if (!reset) begin
      txPending = 1'b0;
      txHold    = 0;
      tx_done   = 1'b0;
    end else begin
      if (tx_start) begin
        rxLog.push_back(tx_data);
        if (expQ.size() == 0) checkOutput("scoreboardUnderflow", 1, 0);
        else checkOutput("scoreboardByte", tx_data, expQ.pop_front());
        txPending = 1'b1;
        txCd = randLatency ? int'($urandom_range(2, 6)) : txLatency;
      end else if (txPending && txMode == TX_AUTO) begin
        if (txCd == 0) begin
          txPending = 1'b0;
          txHold    = 2;
        end else begin
          txCd--;
        end
      end
      if (txMode == TX_HIGH) begin
        tx_done = 1'b1;
        txHold  = 0;
      end else if (txMode == TX_LOW) begin
        tx_done = 1'b0;
        txHold  = 0;
      end else if (txHold > 0) begin
        tx_done = 1'b1;
        txHold--;
      end else begin
        tx_done = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [7:0] data);
    @(negedge clock);
    wr_en   = en;
    wr_data = data;
  endtask

  task automatic waitDrain(input int limit, input string name);
    int n = 0;
    while (!(empty && !busy) && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, empty && !busy, 1);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired time=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : mainProc
    int busyCycles;
    int starts;
    int accepted;
    int guard;

    // Reset state.
    repeat (3) @(negedge clock);
    checkOutput("rstCount", count, 0);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstFull", full, 0);
    checkOutput("rstOverflow", overflow, 0);
    checkOutput("rstTxData", tx_data, 8'h00);
    checkOutput("rstTxStart", tx_start, 0);
    checkOutput("rstBusy", busy, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single byte, transmitter answering 20 cycles after start.
    txMode = TX_AUTO;
    txLatency = 20;
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1CountAfterWrite", count, 1);
    checkOutput("t1NoStartYet", tx_start, 0);
    @(negedge clock);
    checkOutput("t1Start", tx_start, 1);
    checkOutput("t1Data", tx_data, 8'hA5);
    checkOutput("t1Busy", busy, 1);
    checkOutput("t1CountAfterPop", count, 0);
    starts = 1;
    busyCycles = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx_start) starts++;
      if (!busy) break;
      busyCycles++;
      checkOutput("t1DataHeld", tx_data, 8'hA5);
    end
    checkOutput("t1StartPulses", starts, 1);
    // Launch cycle + 20 countdown cycles + one cycle for the done edge to land.
    checkOutput("t1BusyCycles", busyCycles, 22);
    waitDrain(100, "t1Drain");

    // Burst of 16 consecutive writes while the first frame is on the line.
    rxLog.delete();
    peakCount = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i));
    applyStimulus(1'b0, 8'h00);
    waitDrain(1000, "t3Drain");
    checkOutput("t3Peak", peakCount, 15);
    checkOutput("t3RxCount", rxLog.size(), 16);
    for (int i = 0; i < 16 && i < rxLog.size(); i++) checkOutput("t3Order", rxLog[i], i);
    checkOutput("t3Empty", empty, 1);

    // Overflow: one byte leaves for the line at once, so DEPTH+2 writes are
    // needed to force a drop while tx_done is held low.
    txMode = TX_LOW;
    txLatency = 3;
    rxLog.delete();
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 8'(8'h40 + i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4Full", full, 1);
    checkOutput("t4Count", count, 16);
    checkOutput("t4Overflow", overflow, 1);
    txMode = TX_AUTO;
    waitDrain(1000, "t4Drain");
    checkOutput("t4OverflowSticky", overflow, 1);
    checkOutput("t4RxCount", rxLog.size(), 17);
    if (rxLog.size() > 16) checkOutput("t4LastByte", rxLog[16], 8'h50);

    // tx_done already high when the frame launches: only a fresh edge ends it.
    txMode = TX_HIGH;
    repeat (2) @(negedge clock);
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b0, 8'h00);
    repeat (10) @(negedge clock);
    checkOutput("t5StillBusy", busy, 1);
    txMode = TX_AUTO;
    waitDrain(200, "t5Drain");
    checkOutput("t5Idle", busy, 0);

    // Reset during WAIT with five bytes queued.
    txMode = TX_LOW;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h60 + i));
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(negedge clock);
    checkOutput("t6Queued", count, 5);
    checkOutput("t6BusyBefore", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6Count", count, 0);
    checkOutput("t6Empty", empty, 1);
    checkOutput("t6Full", full, 0);
    checkOutput("t6Overflow", overflow, 0);
    checkOutput("t6TxData", tx_data, 8'h00);
    checkOutput("t6TxStart", tx_start, 0);
    checkOutput("t6Busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    txMode = TX_AUTO;
    starts = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (tx_start) starts++;
    end
    checkOutput("t6NoStarts", starts, 0);

    // Random write pattern across pointer wrap, random line latency.
    randLatency = 1'b1;
    rxLog.delete();
    peakCount = 0;
    accepted = 0;
    guard = 0;
    while (accepted < 40 && guard < 5000) begin
      @(negedge clock);
      guard++;
      if ($urandom_range(0, 2) == 0 && !full) begin
        wr_en   = 1'b1;
        wr_data = 8'($urandom);
        accepted++;
      end else begin
        wr_en = 1'b0;
      end
    end
    checkOutput("t7WriteBudget", accepted, 40);
    @(negedge clock);
    wr_en = 1'b0;
    waitDrain(3000, "t7Drain");
    checkOutput("t7RxCount", rxLog.size(), 40);
    checkOutput("t7ScoreboardEmpty", expQ.size(), 0);
    checkOutput("t7PeakWithinDepth", peakCount <= DEPTH, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
